ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 Parameter CPU_WIDTH, default 64, is the PC width; the instruction width is fixed at 32.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 o_req_valid  output  1  fetch request valid to instruction memory.
REQ-006 i_req_ready  input  1  memory accepts the request this cycle.
REQ-007 o_req_addr  output  CPU_WIDTH  fetch address, 4-byte aligned.
REQ-008 i_rsp_valid  input  1  read data valid.
REQ-009 i_rsp_data  input  32  fetched instruction word.
REQ-010 o_ins_valid  output  1  instruction available to the decode stage.
REQ-011 i_ins_ready  input  1  decode stage consumes the instruction this cycle.
REQ-012 o_ins  output  32  instruction to decode.
REQ-013 o_pc  output  CPU_WIDTH  PC of o_ins.
REQ-014 i_redirect  input  1  PC redirect from the PC unit (branch taken, jal, jalr).
REQ-015 i_redirect_pc  input  CPU_WIDTH  redirect target; bits [1:0] are ignored and treated as zero.

Function
REQ-016 The block SHALL be an FSM with states IDLE, REQ, WAIT and OUT, plus a pc register and a kill flag.
REQ-017 IDLE: all outputs are inactive; the FSM moves unconditionally to REQ on the next cycle.
REQ-018 REQ: o_req_valid=1 and o_req_addr=pc; on i_req_ready the FSM moves to WAIT.
REQ-019 At most one request SHALL be outstanding; o_req_valid SHALL be 0 in WAIT and OUT.
REQ-020 o_req_addr SHALL stay stable while o_req_valid=1 and i_req_ready=0, except when a redirect occurs.
REQ-021 WAIT, i_rsp_valid=1, kill=0: o_ins<=i_rsp_data, o_pc<=pc, pc<=pc+4, next state OUT.
REQ-022 WAIT, i_rsp_valid=1, kill=1: the response SHALL be dropped, kill<=0, next state REQ.
REQ-023 OUT: o_ins_valid=1; on i_ins_ready the FSM moves to REQ and o_ins is cleared to 32'h0.
REQ-024 Minimum latency with zero-wait memory: the request is accepted in cycle N, the response arrives in N+1, and o_ins_valid=1 in N+2.
REQ-025 Peak throughput SHALL be one instruction per 3 cycles.
REQ-026 pc arithmetic SHALL be modulo 2^CPU_WIDTH, so pc+4 wraps from all-ones-minus-3 to 0.
REQ-027 Redirect rule: pc<=i_redirect_pc with bits [1:0] set to 0, in every state other than IDLE.
REQ-028 Redirect in REQ without acceptance: the FSM stays in REQ, and o_req_addr shows the new pc next cycle.
REQ-029 Redirect in REQ with i_req_ready=1: the accepted old-pc request is in flight, kill<=1, next state WAIT.
REQ-030 Redirect in WAIT without i_rsp_valid: kill<=1 and the FSM stays in WAIT.
REQ-031 Redirect in WAIT with i_rsp_valid=1: the response is dropped, kill<=0, next state REQ.
REQ-032 Redirect in OUT: the buffered instruction is discarded, o_ins_valid deasserts next cycle, o_ins<=0, next state REQ; redirect has priority over i_ins_ready.
REQ-033 i_rsp_valid outside WAIT SHALL be ignored.
REQ-034 o_ins SHALL read 32'h0 whenever o_ins_valid=0, so decode sees an all-zero word, which is exempt from decode-error checking.

Reset
REQ-035 On i_rst=1 at a clock edge: state<=IDLE, pc<=RESET_PC, kill<=0, o_ins_valid=0, o_ins<=0, o_pc<=0, o_req_valid=0.
REQ-036 Reset SHALL override redirect, handshakes and responses in the same cycle, and SHALL abandon any outstanding request.
REQ-037 The memory is reset by the same i_rst, so no response for an abandoned request arrives afterwards.

Structure
REQ-038 CPU_WIDTH, INS_WIDTH=32, RESET_PC and the FSM state typedef (ifu_state_t) SHALL live in the shared config package.
REQ-039 The optional sub-module ifu_outbuf SHALL hold o_ins/o_pc/o_ins_valid with load, clear and hold controls; all other logic stays in ifu.

Verification
REQ-040 Reset release, zero-wait memory returning 32'h00000413 -> request addr 0x80000000 in the cycle after IDLE; o_ins=32'h00000413, o_pc=0x80000000 two cycles later.
REQ-041 i_ins_ready held 0 for 5 cycles -> o_ins/o_pc stable, no new request; after ready, the next request addr is 0x80000004.
REQ-042 i_req_ready held 0 for 3 cycles -> o_req_valid stays 1 with a stable addr and no response is consumed.
REQ-043 Redirect to 0x80000102 in WAIT, then the response arrives -> response dropped, o_ins_valid stays 0, next request addr 0x80000100.
REQ-044 Redirect and i_ins_ready in the same OUT cycle -> the buffered instruction is not re-presented and the next request addr equals the redirect target.
REQ-045 i_rst asserted during WAIT with a later stray i_rsp_valid -> outputs are at reset values, and the first request after IDLE is to RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset address and FSM state type for the fetch unit
package ifu_pkg;
  localparam int CPU_WIDTH = 64;
  localparam int INS_WIDTH = 32;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} ifu_state_t;
endpackage

// File: rtl/ifu_outbuf.sv
// ifu_outbuf: instruction/pc holding register toward decode, word reads zero when empty
module ifu_outbuf
  import ifu_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [INS_WIDTH-1:0] d_ins,
  input  logic [PC_W-1:0]      d_pc,
  output logic                 ins_valid,
  output logic [INS_WIDTH-1:0] ins,
  output logic [PC_W-1:0]      pc
);
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_valid <= 1'b0;
      ins <= '0;
      pc <= '0;
    end else if (load) begin
      ins_valid <= 1'b1;
      ins <= d_ins;
      pc <= d_pc;
    end else if (clear) begin
      ins_valid <= 1'b0;
      ins <= '0;
    end
  end
endmodule

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch FSM with redirect kill of in-flight responses
module ifu #(
  parameter int CPU_WIDTH = ifu_pkg::CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = CPU_WIDTH'(ifu_pkg::RESET_PC)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  output logic                          o_req_valid,
  input  logic                          i_req_ready,
  output logic [CPU_WIDTH-1:0]          o_req_addr,
  input  logic                          i_rsp_valid,
  input  logic [ifu_pkg::INS_WIDTH-1:0] i_rsp_data,
  output logic                          o_ins_valid,
  input  logic                          i_ins_ready,
  output logic [ifu_pkg::INS_WIDTH-1:0] o_ins,
  output logic [CPU_WIDTH-1:0]          o_pc,
  input  logic                          i_redirect,
  input  logic [CPU_WIDTH-1:0]          i_redirect_pc
);
  import ifu_pkg::*;
  ifu_state_t state;
  logic [CPU_WIDTH-1:0] pc;
  logic [CPU_WIDTH-1:0] rd_pc;
  logic kill;
  logic load;
  logic clear;
  assign rd_pc = i_redirect_pc & ~CPU_WIDTH'(3);
  assign o_req_valid = state == REQ;
  assign o_req_addr = pc;
  assign load = state == WAIT && i_rsp_valid && !kill && !i_redirect;
  assign clear = state == OUT && (i_redirect || i_ins_ready);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      kill <= 1'b0;
    end else begin
      if (i_redirect && state != IDLE) pc <= rd_pc;
      case (state)
        IDLE: state <= REQ;
        REQ: if (i_req_ready) begin
          state <= WAIT;
          kill <= i_redirect;
        end
        WAIT: if (i_rsp_valid) begin
          state <= load ? OUT : REQ;
          kill <= 1'b0;
          if (load) pc <= pc + CPU_WIDTH'(4);
        end else if (i_redirect) kill <= 1'b1;
        OUT: if (clear) state <= REQ;
      endcase
    end
  end
  ifu_outbuf #(.PC_W(CPU_WIDTH)) u_outbuf (
    .clk(i_clk),
    .rst(i_rst),
    .load(load),
    .clear(clear),
    .d_ins(i_rsp_data),
    .d_pc(pc),
    .ins_valid(o_ins_valid),
    .ins(o_ins),
    .pc(o_pc)
  );
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed scoreboard bench for the fetch unit
module tb_ifu;
  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } exp_t;
  logic i_clk;
  logic i_rst;
  logic o_req_valid;
  logic i_req_ready;
  logic [63:0] o_req_addr;
  logic i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic o_ins_valid;
  logic i_ins_ready;
  logic [31:0] o_ins;
  logic [63:0] o_pc;
  logic i_redirect;
  logic [63:0] i_redirect_pc;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  ifu dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .o_req_valid(o_req_valid),
    .i_req_ready(i_req_ready),
    .o_req_addr(o_req_addr),
    .i_rsp_valid(i_rsp_valid),
    .i_rsp_data(i_rsp_data),
    .o_ins_valid(o_ins_valid),
    .i_ins_ready(i_ins_ready),
    .o_ins(o_ins),
    .o_pc(o_pc),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge i_clk);
  endtask
  task automatic chk_req(input string tag, input logic [63:0] addr);
    chk({tag, "_req_valid"}, 64'(o_req_valid), 64'd1);
    chk({tag, "_req_addr"}, o_req_addr, addr);
  endtask
  task automatic chk_empty(input string tag);
    chk({tag, "_ins_valid"}, 64'(o_ins_valid), 64'd0);
    chk({tag, "_ins_zero"}, 64'(o_ins), 64'd0);
  endtask
  task automatic accept;
    i_req_ready = 1'b1;
    tick;
    i_req_ready = 1'b0;
    chk("wait_no_req", 64'(o_req_valid), 64'd0);
  endtask
  task automatic respond(input logic [31:0] data);
    i_rsp_valid = 1'b1;
    i_rsp_data = data;
    tick;
    i_rsp_valid = 1'b0;
    i_rsp_data = $urandom;
  endtask
  task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input int hold);
    exp_t x;
    chk_req("fetch", addr);
    sb.push_back('{ins: data, pc: addr});
    accept;
    chk("wait_no_ins", 64'(o_ins_valid), 64'd0);
    respond(data);
    x = sb.pop_front();
    chk("out_valid", 64'(o_ins_valid), 64'd1);
    chk("out_ins", 64'(o_ins), 64'(x.ins));
    chk("out_pc", o_pc, x.pc);
    chk("out_no_req", 64'(o_req_valid), 64'd0);
    for (int k = 0; k < hold; k++) begin
      tick;
      chk("hold_valid", 64'(o_ins_valid), 64'd1);
      chk("hold_ins", 64'(o_ins), 64'(x.ins));
      chk("hold_pc", o_pc, x.pc);
      chk("hold_no_req", 64'(o_req_valid), 64'd0);
    end
    i_ins_ready = 1'b1;
    tick;
    i_ins_ready = 1'b0;
    chk_empty("consumed");
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 64'(o_req_valid), 64'd0);
    chk_empty(tag);
    chk({tag, "_pc"}, o_pc, 64'd0);
  endtask
  initial begin
    i_rst = 1'b1;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_data = '0;
    i_ins_ready = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    tick;
    tick;
    chk_reset("reset");
    i_rst = 1'b0;
    tick;
    fetch(64'h8000_0000, 32'h0000_0413, 5);
    fetch(64'h8000_0004, 32'h1234_5678, 0);
    i_rsp_valid = 1'b1;
    i_rsp_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_req("stall", 64'h8000_0008);
      chk("stall_no_ins", 64'(o_ins_valid), 64'd0);
    end
    i_rsp_valid = 1'b0;
    fetch(64'h8000_0008, 32'hCAFE_0001, 0);
    accept;
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0102;
    tick;
    i_redirect = 1'b0;
    chk("kill_wait_no_req", 64'(o_req_valid), 64'd0);
    respond(32'hBAD0_0001);
    chk_empty("kill_drop");
    chk_req("kill_next", 64'h8000_0100);
    fetch(64'h8000_0100, 32'h0000_0013, 0);
    chk_req("out_redir", 64'h8000_0104);
    accept;
    respond(32'h5555_AAAA);
    chk("out_redir_valid", 64'(o_ins_valid), 64'd1);
    chk("out_redir_ins", 64'(o_ins), 64'h5555_AAAA);
    i_ins_ready = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0201;
    tick;
    i_ins_ready = 1'b0;
    i_redirect = 1'b0;
    chk_empty("out_redir_drop");
    chk_req("out_redir_next", 64'h8000_0200);
    fetch(64'h8000_0200, 32'h0BAD_F00D, 0);
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0303;
    tick;
    chk_req("req_redir", 64'h8000_0300);
    i_redirect_pc = 64'h8000_0400;
    i_req_ready = 1'b1;
    tick;
    i_redirect = 1'b0;
    i_req_ready = 1'b0;
    chk("req_redir_acc_wait", 64'(o_req_valid), 64'd0);
    respond(32'hBAD0_0002);
    chk_empty("req_redir_drop");
    chk_req("req_redir_next", 64'h8000_0400);
    fetch(64'h8000_0400, 32'h0040_0093, 0);
    accept;
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0500;
    respond(32'hBAD0_0003);
    i_redirect = 1'b0;
    chk_empty("wait_redir_rsp");
    chk_req("wait_redir_rsp_next", 64'h8000_0500);
    i_redirect = 1'b1;
    i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    i_redirect = 1'b0;
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_0001, 0);
    chk_req("wrap", 64'h0);
    accept;
    i_rst = 1'b1;
    tick;
    chk_reset("mid_reset");
    i_rst = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_data = 32'hBAD0_0004;
    tick;
    chk_req("post_reset", 64'h8000_0000);
    chk_empty("post_reset_stray");
    tick;
    chk_empty("post_reset_stray2");
    i_rsp_valid = 1'b0;
    fetch(64'h8000_0000, 32'h0000_0413, 0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
